// File: rtl/s344_divider_if.sv
// rtl/s344_divider_if.sv - START/READY operand and result bundle for the 8-by-4 divider.
interface s344_divider_if;
  logic       START;
  logic [7:0] P;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       READY;
  logic       OVF;

  modport master (output START, P, B, input Q, R, READY, OVF);
  modport slave  (input START, P, B, output Q, R, READY, OVF);
endinterface

// File: rtl/s344_divider.sv
// rtl/s344_divider.sv - Sequential 8-by-4 restoring divider, one shift-subtract step per clock.
module s344_divider (
  input logic           CK,
  input logic           RN,
  s344_divider_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] pr_q, pr_d;
  logic [3:0] dl_q, dl_d;
  logic [3:0] br_q, br_d;
  logic [3:0] qs_q, qs_d;
  logic [2:0] ct_q, ct_d;
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       ovf_q, ovf_d;

  logic [4:0] trial;
  logic [4:0] diff;
  logic       qbit;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      pr_q    <= 4'h0;
      dl_q    <= 4'h0;
      br_q    <= 4'h0;
      qs_q    <= 4'h0;
      ct_q    <= 3'd0;
      q_q     <= 4'h0;
      r_q     <= 4'h0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      dl_q    <= dl_d;
      br_q    <= br_d;
      qs_q    <= qs_d;
      ct_q    <= ct_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
    end
  end

  // PR < BR is kept at every step, so the 5-bit trial never loses a bit.
  assign trial = {pr_q, dl_q[3]};
  assign diff  = trial - {1'b0, br_q};
  assign qbit  = (trial >= {1'b0, br_q});

  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    dl_d    = dl_q;
    br_d    = br_q;
    qs_d    = qs_q;
    ct_d    = ct_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;

    if (bus.START) begin
      if ((bus.B == 4'h0) || (bus.P[7:4] >= bus.B)) begin
        q_d     = 4'hF;
        r_d     = 4'h0;
        ovf_d   = 1'b1;
        state_d = IDLE;
      end else begin
        pr_d    = bus.P[7:4];
        dl_d    = bus.P[3:0];
        br_d    = bus.B;
        qs_d    = 4'h0;
        ct_d    = 3'd0;
        ovf_d   = 1'b0;
        state_d = BUSY;
      end
    end else if (state_q == BUSY) begin
      pr_d = qbit ? diff[3:0] : trial[3:0];
      dl_d = {dl_q[2:0], 1'b0};
      qs_d = {qs_q[2:0], qbit};
      ct_d = ct_q + 3'd1;
      if (ct_q == 3'd3) begin
        q_d     = {qs_q[2:0], qbit};
        r_d     = pr_d;
        state_d = IDLE;
      end
    end
  end

  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.OVF   = ovf_q;
  assign bus.READY = (state_q == IDLE);

endmodule

// File: tb/tb_s344_divider.sv
// tb/tb_s344_divider.sv - Randomized self-checking bench for s344_divider against an arithmetic model.
module tb_s344_divider;

  logic CK;
  logic RN;
  s344_divider_if bus ();

  s344_divider dut (.CK(CK), .RN(RN), .bus(bus.slave));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: results come from / and %, a countdown stands in for the busy period.
  logic       m_ready;
  logic       m_ovf;
  logic [3:0] m_q, m_r, m_pq, m_pr;
  int         m_cnt;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_ready = 1'b1; m_ovf = 1'b0; m_q = 4'h0; m_r = 4'h0; m_cnt = 0;
    end else if (bus.START) begin
      if (bus.B == 0 || (int'(bus.P) / int'(bus.B)) > 15) begin
        m_q = 4'hF; m_r = 4'h0; m_ovf = 1'b1; m_ready = 1'b1; m_cnt = 0;
      end else begin
        m_ovf   = 1'b0;
        m_ready = 1'b0;
        m_cnt   = 4;
        m_pq    = 4'(int'(bus.P) / int'(bus.B));
        m_pr    = 4'(int'(bus.P) % int'(bus.B));
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ready = 1'b1; m_q = m_pq; m_r = m_pr;
      end
    end
  end

  always @(negedge CK) begin
    chk("model_ready", int'(bus.READY), int'(m_ready));
    chk("model_ovf",   int'(bus.OVF),   int'(m_ovf));
    chk("model_q",     int'(bus.Q),     int'(m_q));
    chk("model_r",     int'(bus.R),     int'(m_r));
  end

  task automatic pulse(input logic [7:0] p, input logic [3:0] b);
    @(negedge CK);
    bus.START = 1'b1; bus.P = p; bus.B = b;
    @(negedge CK);
    bus.START = 1'b0;
  endtask

  // Called right after pulse: counts edges until READY and pins literal results.
  task automatic wait_check(input string name, input int eq, input int er, input int eovf);
    int n;
    n = 0;
    if (eovf == 0) begin
      chk({name, "_busy"}, int'(bus.READY), 0);
      while (!bus.READY && n < 12) begin
        @(negedge CK);
        n++;
      end
      chk({name, "_latency"}, n, 4);
    end else begin
      chk({name, "_ready_held"}, int'(bus.READY), 1);
    end
    chk({name, "_q"},   int'(bus.Q),   eq);
    chk({name, "_r"},   int'(bus.R),   er);
    chk({name, "_ovf"}, int'(bus.OVF), eovf);
  endtask

  initial begin
    bus.START = 1'b0; bus.P = 8'h00; bus.B = 4'h0;
    RN = 1'b0;
    repeat (3) @(negedge CK);
    chk("rst_ready", int'(bus.READY), 1);
    chk("rst_ovf",   int'(bus.OVF),   0);
    chk("rst_q",     int'(bus.Q),     0);
    chk("rst_r",     int'(bus.R),     0);
    RN = 1'b1;
    repeat (2) @(negedge CK);
    chk("post_rst_ready", int'(bus.READY), 1);
    chk("post_rst_q",     int'(bus.Q),     0);

    pulse(8'd143, 4'd11); wait_check("exact",  13, 0, 0);
    pulse(8'd100, 4'd7);  wait_check("rem",    14, 2, 0);
    pulse(8'd239, 4'd15); wait_check("max",    15, 14, 0);
    pulse(8'd0,   4'd5);  wait_check("zero",   0, 0, 0);
    pulse(8'd77,  4'd0);  wait_check("div0",   15, 0, 1);
    pulse(8'd100, 4'd7);  wait_check("clear",  14, 2, 0);
    pulse(8'h50,  4'd5);  wait_check("ovf_hi", 15, 0, 1);
    pulse(8'd143, 4'd11); wait_check("clear2", 13, 0, 0);

    // Abort: the second START lands on the second step edge.
    pulse(8'd143, 4'd11);
    pulse(8'd100, 4'd7);
    wait_check("abort", 14, 2, 0);

    pulse(8'd143, 4'd11);
    @(negedge CK);
    @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("mid_rst_ready", int'(bus.READY), 1);
    chk("mid_rst_q",     int'(bus.Q),     0);
    chk("mid_rst_r",     int'(bus.R),     0);
    @(negedge CK);
    RN = 1'b1;

    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        pulse(8'(a * b), 4'(b));
        wait_check("round_trip", a, 0, 0);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge CK);
      if ($urandom_range(0, 5) == 0) begin
        bus.START = 1'b1;
        bus.B = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0)
          bus.P = 8'($urandom_range(0, 255));
        else
          bus.P = 8'(int'(bus.B) * $urandom_range(0, 15) + $urandom_range(0, 15) % (int'(bus.B) + 1));
      end else begin
        bus.START = 1'b0;
      end
      if ($urandom_range(0, 400) == 0) begin
        #2 RN = 1'b0;
        #4 RN = 1'b1;
      end
    end
    @(negedge CK);
    bus.START = 1'b0;
    repeat (8) @(negedge CK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/s344_divider.md
# s344_divider

Sequential 8-by-4 restoring divider, the inverse of the 4x4 add-shift multiplier block. It takes an 8-bit product/dividend P and a 4-bit divisor B. It then iterates one shift-subtract step per clock and returns a 4-bit quotient and a 4-bit remainder. It uses the same START/READY handshake as the multiplier, so the two can be chained for round-trip checking (P = A*B, then P/B = A, remainder 0).

## Interface
- No parameters; widths are fixed at dividend 8, divisor/quotient/remainder 4.
- CK  in  1  clock, rising-edge.
- RN  in  1  reset, asynchronous, active-low.
- START  in  1  sampled on the CK edge; high loads operands and begins (or restarts) a division.
- P0..P7  in  1 each  dividend, P0 is the LSB; sampled only on the edge that sees START high.
- B0..B3  in  1 each  divisor, B0 is the LSB; sampled only on the edge that sees START high.
- Q0..Q3  out  1 each  quotient, registered.
- R0..R3  out  1 each  remainder, registered.
- READY  out  1  high when idle and results are valid.
- OVF  out  1  high when the last operation was rejected (B==0 or quotient would exceed 4 bits).

## Operation
- Internal state:
  - 4-bit partial remainder PR;
  - 4-bit dividend-low shift register DL;
  - 4-bit divisor register BR;
  - 4-bit quotient shift register QS;
  - 3-bit step counter CT;
  - state in {IDLE, BUSY}.
- Overflow test on a START edge: if B==0 or P[7:4] >= B, then at that edge:
  - Q=4'hF, R=4'h0, OVF=1;
  - stay in IDLE with READY=1.
- Normal load on a START edge:
  - PR=P[7:4], DL=P[3:0], BR=B, QS=0, CT=0;
  - state=BUSY, READY=0;
  - OVF cleared; Q/R outputs keep their previous values.
- Each BUSY edge:
  - T = {PR, DL[3]} (5 bits);
  - if T >= {1'b0,BR} then PR = (T - BR)[3:0] and qbit=1, else PR = T[3:0] and qbit=0;
  - DL shifts left with 0 in; QS = {QS[2:0], qbit}; CT increments.
- The invariant PR < BR holds at every step, so PR always fits in 4 bits. The subtraction is 5-bit unsigned.
- After the 4th step (CT reaches 4 during that edge):
  - Q=QS with the final qbit included, R=PR;
  - state=IDLE, READY=1.
- START high while BUSY aborts the current operation and reloads per the rules above. No result from the aborted operation is written.
- START high while IDLE is always accepted.
- START is level-sampled. If it is held high, the block reloads on every edge and never completes.

## Timing
- Reset values (RN low, asynchronous): state=IDLE, READY=1, OVF=0, Q=0, R=0, PR=DL=BR=QS=0, CT=0.
- RN deassertion is assumed synchronized upstream. The first active edge after release behaves as IDLE.
- Latency, START sampled at edge k (START low afterwards):
  - READY=0 after edge k;
  - steps at edges k+1..k+4;
  - READY=1 with Q/R valid after edge k+4, i.e. a 4-cycle BUSY period.
- Overflow latency: READY never drops; Q/R/OVF are updated after edge k.
- Back-to-back: START may be asserted on the same edge that completes (k+4). The block then loads the new operation and the completing result is discarded. Software therefore waits for READY=1 before restarting.
- Reset mid-operation immediately forces the reset values; no partial result appears.

## Test plan
- Reset: RN low with CK running -> READY=1, OVF=0, Q=0, R=0. Releasing RN -> the values hold.
- Exact product: P=143 (8'h8F), B=11, START one cycle -> READY low for 4 cycles, then Q=13, R=0, OVF=0.
- Remainder and boundary: P=100, B=7 -> Q=14, R=2. P=239, B=15 -> Q=15, R=14. P=0, B=5 -> Q=0, R=0. Each case has latency exactly 4 edges after START.
- Overflow: B=0 with any P -> Q=15, R=0, OVF=1, READY stays 1. P=8'h50, B=5 -> OVF=1. A following valid START clears OVF.
- Abort and reset: start P=143/B=11, then assert START at step 2 with P=100/B=7 -> the final result is Q=14, R=2, READY 4 edges after the second START. Separately, pulse RN low at step 3 -> the reset values appear immediately.
- Round trip against the multiplier: all A,B in 1..15, feed P=A*B and B -> Q=A and R=0 in every case.
